dcache_req_queue: RTL and testbench

Parametrised request queue between the CPU memory stage and the data cache upstream port. It buffers up to DEPTH load/store requests in order. It presents the oldest one to the cache and holds it stable until the cache pulses `ufp_resp`. Unlike a single-entry holding register, it accepts new requests while earlier ones are outstanding and exposes backpressure and occupancy.

---
 rtl/dcache_req_queue.sv | 125 ++++++++++++
 tb/tb_dcache_req_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_req_queue.sv
// dcache_req_queue: in-order FIFO of CPU load/store requests feeding the data
// cache upstream port. The oldest entry is presented on ufp_* and held until
// ufp_resp. Optional feature macro: DCACHE_REQ_BYPASS_EN (empty-queue request
// is presented combinationally and may complete without being enqueued).
module dcache_req_queue #(
    parameter  int unsigned ADDR_W = 32,
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned MASK_W = DATA_W / 8,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [MASK_W-1:0] cpu_rmask,
    input  logic [MASK_W-1:0] cpu_wmask,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] ufp_addr,
    output logic [MASK_W-1:0] ufp_rmask,
    output logic [MASK_W-1:0] ufp_wmask,
    output logic [DATA_W-1:0] ufp_wdata,
    input  logic              ufp_resp,
    output logic [CNT_W-1:0]  count,
    output logic              spurious_resp
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Entry storage; contents are qualified by count, so no reset is needed.
    logic [ADDR_W-1:0] entry_addr_q  [DEPTH];
    logic [MASK_W-1:0] entry_rmask_q [DEPTH];
    logic [MASK_W-1:0] entry_wmask_q [DEPTH];
    logic [DATA_W-1:0] entry_wdata_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             spurious_q, spurious_d;

    logic req_valid;
    logic empty;
    logic accept;
    logic bypass_done;
    logic push;
    logic pop;

    // Handshake decode and next-state for pointers, occupancy and spurious flag.
    always_comb begin
        req_valid = (cpu_rmask != '0) || (cpu_wmask != '0);
        empty     = (count_q == '0);
        cpu_ready = (count_q < CNT_W'(DEPTH)) || ufp_resp;
        accept    = req_valid && cpu_ready;
`ifdef DCACHE_REQ_BYPASS_EN
        bypass_done = empty && req_valid && ufp_resp;
`else
        bypass_done = 1'b0;
`endif
        push = accept && !bypass_done;
        pop  = ufp_resp && !empty;

        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        spurious_d = ufp_resp && empty && !bypass_done;
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
        end
    end

    // Write an accepted request into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr_q[wr_ptr_q]  <= cpu_addr;
            entry_rmask_q[wr_ptr_q] <= cpu_rmask;
            entry_wmask_q[wr_ptr_q] <= cpu_wmask;
            entry_wdata_q[wr_ptr_q] <= cpu_wdata;
        end
    end

    // Present the head entry; all-zero when nothing is presented.
    always_comb begin
        ufp_addr  = '0;
        ufp_rmask = '0;
        ufp_wmask = '0;
        ufp_wdata = '0;
        if (!empty) begin
            ufp_addr  = entry_addr_q[rd_ptr_q];
            ufp_rmask = entry_rmask_q[rd_ptr_q];
            ufp_wmask = entry_wmask_q[rd_ptr_q];
            ufp_wdata = entry_wdata_q[rd_ptr_q];
        end
`ifdef DCACHE_REQ_BYPASS_EN
        else if (req_valid) begin
            ufp_addr  = cpu_addr;
            ufp_rmask = cpu_rmask;
            ufp_wmask = cpu_wmask;
            ufp_wdata = cpu_wdata;
        end
`endif
    end

    assign count         = count_q;
    assign spurious_resp = spurious_q;

endmodule

// File: tb/tb_dcache_req_queue.sv
// Randomized + directed bench for dcache_req_queue against a queue-based model.
module tb_dcache_req_queue;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

`ifdef DCACHE_REQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] rmask;
        logic [MASK_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
    } req_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] cpu_addr;
    logic [MASK_W-1:0] cpu_rmask;
    logic [MASK_W-1:0] cpu_wmask;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [ADDR_W-1:0] ufp_addr;
    logic [MASK_W-1:0] ufp_rmask;
    logic [MASK_W-1:0] ufp_wmask;
    logic [DATA_W-1:0] ufp_wdata;
    logic              ufp_resp;
    logic [CNT_W-1:0]  count;
    logic              spurious_resp;

    dcache_req_queue #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_addr     (cpu_addr),
        .cpu_rmask    (cpu_rmask),
        .cpu_wmask    (cpu_wmask),
        .cpu_wdata    (cpu_wdata),
        .cpu_ready    (cpu_ready),
        .ufp_addr     (ufp_addr),
        .ufp_rmask    (ufp_rmask),
        .ufp_wmask    (ufp_wmask),
        .ufp_wdata    (ufp_wdata),
        .ufp_resp     (ufp_resp),
        .count        (count),
        .spurious_resp(spurious_resp)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: pending requests in arrival order, plus expected pulse.
    req_t model_q[$];
    bit   exp_spur = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check outputs, then update the model at posedge.
    task automatic cycle(input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] rm,
                         input logic [MASK_W-1:0] wm, input logic [DATA_W-1:0] wd,
                         input logic resp);
        req_t r;
        req_t exp_head;
        bit   valid, ready, pop, bdone, push;
        @(negedge clk);
        cpu_addr  = a;
        cpu_rmask = rm;
        cpu_wmask = wm;
        cpu_wdata = wd;
        ufp_resp  = resp;
        #1;
        r.addr = a; r.rmask = rm; r.wmask = wm; r.wdata = wd;
        valid = (rm != 0) || (wm != 0);
        ready = (model_q.size() < DEPTH) || resp;

        if (model_q.size() > 0) begin
            exp_head = model_q[0];
        end else if (BYPASS && valid) begin
            exp_head = r;
        end else begin
            exp_head.addr = '0; exp_head.rmask = '0; exp_head.wmask = '0; exp_head.wdata = '0;
        end

        check("count",     64'(count),         64'(model_q.size()));
        check("cpu_ready", 64'(cpu_ready),     64'(ready));
        check("spurious",  64'(spurious_resp), 64'(exp_spur));
        check("ufp_addr",  64'(ufp_addr),      64'(exp_head.addr));
        check("ufp_rmask", 64'(ufp_rmask),     64'(exp_head.rmask));
        check("ufp_wmask", 64'(ufp_wmask),     64'(exp_head.wmask));
        check("ufp_wdata", 64'(ufp_wdata),     64'(exp_head.wdata));

        bdone = BYPASS && (model_q.size() == 0) && valid && resp;
        pop   = resp && (model_q.size() > 0);
        push  = valid && ready && !bdone;

        @(posedge clk);
        exp_spur = resp && (model_q.size() == 0) && !bdone;
        if (pop)  void'(model_q.pop_front());
        if (push) model_q.push_back(r);
    endtask

    task automatic idle(input logic resp);
        cycle('0, '0, '0, '0, resp);
    endtask

    // Assert reset away from any clock edge and check the immediate effect.
    task automatic async_reset();
        @(negedge clk);
        cpu_rmask = '0;
        cpu_wmask = '0;
        ufp_resp  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_count", 64'(count),         64'd0);
        check("rst_rmask", 64'(ufp_rmask),     64'd0);
        check("rst_wmask", 64'(ufp_wmask),     64'd0);
        check("rst_addr",  64'(ufp_addr),      64'd0);
        check("rst_wdata", 64'(ufp_wdata),     64'd0);
        check("rst_spur",  64'(spurious_resp), 64'd0);
        model_q.delete();
        exp_spur = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_addr  = '0;
        cpu_rmask = '0;
        cpu_wmask = '0;
        cpu_wdata = '0;
        ufp_resp  = 1'b0;
        #13;
        check("init_count", 64'(count),     64'd0);
        check("init_rmask", 64'(ufp_rmask), 64'd0);
        check("init_wmask", 64'(ufp_wmask), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single load: presented next cycle, completed by resp.
        cycle(32'h100, 4'hF, 4'h0, 32'h0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill, hold a fifth request while full, then push-with-pop and drain.
        for (int i = 0; i < 4; i++) cycle(32'(i * 4), 4'hF, 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(32'h10, 4'hF, 4'h0, 32'h0, 1'b0);
        cycle(32'h10, 4'hF, 4'h0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);
        idle(1'b0);

        // Ten requests with resp every cycle: pointer wrap, order preserved.
        for (int i = 0; i < 10; i++) cycle(32'h1000 + 32'(i * 4), 4'h0, 4'hF, 32'(i), 1'b1);
        idle(1'b1);
        idle(1'b0);

        // Response with nothing presented.
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        // Reset with three entries queued, then a fresh push.
        for (int i = 0; i < 3; i++) cycle(32'h300 + 32'(i), 4'h1, 4'h2, 32'hAA, 1'b0);
        async_reset();
        cycle(32'h200, 4'h3, 4'h0, 32'h0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Store with resp on an empty queue in the same cycle.
        cycle(32'h40, 4'h0, 4'h3, 32'hDEAD_BEEF, 1'b1);
        idle(1'b0);
        idle(1'b0);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            logic [MASK_W-1:0] rm, wm;
            rm = ($urandom_range(0, 2) == 0) ? '0 : MASK_W'($urandom);
            wm = ($urandom_range(0, 2) == 0) ? '0 : MASK_W'($urandom);
            if ($urandom_range(0, 399) == 0) async_reset();
            cycle(ADDR_W'($urandom), rm, wm, DATA_W'($urandom), 1'($urandom_range(0, 99) < 40));
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
